// File: rtl/rap_pkg.sv
// Shared definitions for the rap windowed approximate adder family:
// corrector FSM states and the default operand width / carry window.
package rap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int RAP_W = 8;
  localparam int RAP_K = 4;

endpackage

// File: rtl/rap_apx_sum.sv
// Combinational windowed approximate adder: the carry into each bit is rippled
// only across the K+1 positions ending at that bit, starting from a zero carry.
module rap_apx_sum #(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] ac;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar i = 0; i < W; i++) begin : g_win
    localparam int LO = (i > K) ? (i - K) : 0;
    localparam int N  = i - LO + 1;
    logic [N:0] c;
    assign c[0] = 1'b0;
    for (genvar k = 0; k < N; k++) begin : g_rip
      assign c[k+1] = g[LO+k] | (p[LO+k] & c[k]);
    end
    assign ac[i] = c[N];
  end

  assign sum = {ac[W-1], p[W-1:1] ^ ac[W-2:0], p[0]};

endmodule

// File: rtl/rap_err_corrector.sv
// Evaluates the windowed approximate sum of one operand pair, flags truncated
// carry chains, optionally spends one extra cycle to return the exact sum.
module rap_err_corrector
  import rap_pkg::*;
#(
  parameter int W  = RAP_W,
  parameter int K  = RAP_K,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          corr_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    sum,
  output logic          err,
  output logic          corrected,
  input  logic          clr_cnt,
  output logic [CW-1:0] op_cnt,
  output logic [CW-1:0] err_cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_p0;
  logic [W-1:0]  b_p0;
  logic          corr_p0;
  logic [W:0]    sum_apx;
  logic [W:0]    sum_ex;
  logic          mismatch;
  logic          done;

  // operand capture: IDLE handshake
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_p0    <= a;
      b_p0    <= b;
      corr_p0 <= corr_en;
    end
  end

  rap_apx_sum #(.W(W), .K(K)) u_apx (
    .a   (a_p0),
    .b   (b_p0),
    .sum (sum_apx)
  );

  assign sum_ex   = {1'b0, a_p0} + {1'b0, b_p0};
  assign mismatch = (sum_apx != sum_ex);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign done      = (state == OUT) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    state_nxt = (mismatch && corr_p0) ? FIX : OUT;
      FIX:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // result stage: EVAL loads the approximate sum, FIX overwrites it with the exact one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      err       <= 1'b0;
      corrected <= 1'b0;
    end else if (state == EVAL) begin
      err       <= mismatch;
      corrected <= 1'b0;
      if (!(mismatch && corr_p0)) sum <= sum_apx;
    end else if (state == FIX) begin
      sum       <= sum_ex;
      corrected <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (done) begin
      op_cnt <= sat_inc(op_cnt);
      if (err) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_rap_err_corrector.sv
// Directed bench for rap_err_corrector (W=8, K=4, CW=4) with hand-computed
// expectations and an arithmetic reference for the windowed approximate sum.
module tb_rap_err_corrector;

  localparam int W  = 8;
  localparam int K  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          corr_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    sum;
  logic          err;
  logic          corrected;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] op_cnt;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rap_err_corrector #(.W(W), .K(K), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .corr_en   (corr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .err       (err),
    .corrected (corrected),
    .clr_cnt   (clr_cnt),
    .op_cnt    (op_cnt),
    .err_cnt   (err_cnt)
  );

  // Window carry out of bit i = carry out of adding only bits lo..i of a and b.
  function automatic logic [8:0] ref_apx(input int ai, input int bi);
    logic [8:0] r;
    logic [7:0] ac;
    int lo, n, m, s;
    for (int i = 0; i < 8; i++) begin
      lo = (i > K) ? i - K : 0;
      n  = i - lo + 1;
      m  = (1 << n) - 1;
      s  = ((ai >> lo) & m) + ((bi >> lo) & m);
      ac[i] = ((s >> n) & 1) != 0;
    end
    r[0] = ((ai ^ bi) & 1) != 0;
    for (int i = 1; i < 8; i++) r[i] = ((((ai ^ bi) >> i) & 1) != 0) ^ ac[i-1];
    r[8] = ac[7];
    return r;
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ce,
                        output logic [8:0] rs, output logic re, output logic rc,
                        output int lat);
    in_valid = 1'b1; a = ta; b = tb_; corr_en = ce;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; re = err; rc = corrected;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (sum !== 9'h000) begin n_bad++; $display("FAIL reset_sum got %h want 000", sum); end
    n_cmp++; if ({err, corrected} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {err, corrected}); end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h00) begin n_bad++; $display("FAIL reset_counts got %h want 00", {op_cnt, err_cnt}); end
  endtask

  task automatic test_no_error();
    logic [8:0] rs; logic re, rc; int lat;
    run_op(8'h35, 8'h42, 1'b1, rs, re, rc, lat);
    n_cmp++; if (rs !== 9'h077) begin n_bad++; $display("FAIL noerr_sum got %h want 077", rs); end
    n_cmp++; if ({re, rc} !== 2'b00) begin n_bad++; $display("FAIL noerr_flags got %b want 00", {re, rc}); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL noerr_latency got %0d want 2", lat); end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h10) begin n_bad++; $display("FAIL noerr_counts got %h want 10", {op_cnt, err_cnt}); end
  endtask

  task automatic test_correction();
    logic [8:0] rs; logic re, rc; int lat;
    run_op(8'h7F, 8'h01, 1'b1, rs, re, rc, lat);
    n_cmp++; if (rs !== 9'h080) begin n_bad++; $display("FAIL fix_sum got %h want 080", rs); end
    n_cmp++; if ({re, rc} !== 2'b11) begin n_bad++; $display("FAIL fix_flags got %b want 11", {re, rc}); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL fix_latency got %0d want 3", lat); end
    run_op(8'h7F, 8'h01, 1'b0, rs, re, rc, lat);
    n_cmp++; if (rs !== 9'h040) begin n_bad++; $display("FAIL pass_sum got %h want 040", rs); end
    n_cmp++; if ({re, rc} !== 2'b10) begin n_bad++; $display("FAIL pass_flags got %b want 10", {re, rc}); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL pass_latency got %0d want 2", lat); end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h32) begin n_bad++; $display("FAIL fix_counts got %h want 32", {op_cnt, err_cnt}); end
  endtask

  task automatic test_overflow();
    logic [8:0] rs; logic re, rc; int lat;
    run_op(8'hFF, 8'h01, 1'b0, rs, re, rc, lat);
    n_cmp++; if (rs !== 9'h0C0) begin n_bad++; $display("FAIL ovf_apx_sum got %h want 0C0", rs); end
    n_cmp++; if ({re, rc} !== 2'b10) begin n_bad++; $display("FAIL ovf_apx_flags got %b want 10", {re, rc}); end
    run_op(8'hFF, 8'h01, 1'b1, rs, re, rc, lat);
    n_cmp++; if (rs !== 9'h100) begin n_bad++; $display("FAIL ovf_fix_sum got %h want 100", rs); end
    n_cmp++; if ({re, rc} !== 2'b11) begin n_bad++; $display("FAIL ovf_fix_flags got %b want 11", {re, rc}); end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h54) begin n_bad++; $display("FAIL ovf_counts got %h want 54", {op_cnt, err_cnt}); end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid = 1'b1; a = 8'h7F; b = 8'h01; corr_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid c%0d got %b want 1", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
      n_cmp++; if ({sum, err, corrected} !== {9'h080, 2'b11}) begin
        n_bad++; $display("FAIL bp_hold c%0d got %h/%b%b want 080/11", c, sum, err, corrected);
      end
      if (c == 1) begin in_valid = 1'b1; a = 8'h35; b = 8'h42; corr_en = 1'b0; end
      if (c == 2) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h54) begin n_bad++; $display("FAIL bp_stall_counts got %h want 54", {op_cnt, err_cnt}); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h65) begin n_bad++; $display("FAIL bp_release_counts got %h want 65", {op_cnt, err_cnt}); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
        n_bad++; $display("FAIL bp_ignored c%0d got valid/ready %b want 01", c, {out_valid, in_ready});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic [8:0] rs; logic re, rc; int lat;
    for (int i = 0; i < 20; i++) run_op(8'h7F, 8'h01, 1'b0, rs, re, rc, lat);
    n_cmp++; if ({op_cnt, err_cnt} !== 8'hFF) begin n_bad++; $display("FAIL sat_counts got %h want FF", {op_cnt, err_cnt}); end
    in_valid = 1'b1; a = 8'h35; b = 8'h42; corr_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_wait got valid %b want 1", out_valid); end
    out_ready = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; clr_cnt = 1'b0;
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h00) begin n_bad++; $display("FAIL clr_counts got %h want 00", {op_cnt, err_cnt}); end
    run_op(8'h35, 8'h42, 1'b1, rs, re, rc, lat);
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h10) begin n_bad++; $display("FAIL clr_resume got %h want 10", {op_cnt, err_cnt}); end
  endtask

  task automatic test_sweep();
    logic [7:0] bl [12] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h11, 8'h1F,
                           8'h55, 8'h7F, 8'h80, 8'hAA, 8'hF0, 8'hFF};
    logic [8:0] rs; logic re, rc; int lat;
    logic [8:0] ex; logic ee;
    for (int ai = 0; ai < 256; ai++) begin
      foreach (bl[k]) begin
        run_op(ai[7:0], bl[k], 1'b1, rs, re, rc, lat);
        ex = 9'(ai + int'(bl[k]));
        ee = (ref_apx(ai, int'(bl[k])) != ex);
        n_cmp++; if (rs !== ex) begin n_bad++; $display("FAIL sweep_sum %h+%h got %h want %h", ai[7:0], bl[k], rs, ex); end
        n_cmp++; if ({re, rc} !== {ee, ee}) begin
          n_bad++; $display("FAIL sweep_flags %h+%h got %b want %b", ai[7:0], bl[k], {re, rc}, {ee, ee});
        end
        if (ai < 32 && bl[k] < 8'h20) begin
          n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL sweep_narrow %h+%h got err %b want 0", ai[7:0], bl[k], re); end
        end
      end
    end
    n_cmp++; if ({op_cnt, err_cnt} === 8'h00) begin n_bad++; $display("FAIL sweep_counts got %h want nonzero", {op_cnt, err_cnt}); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; a = 8'h7F; b = 8'h01; corr_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rstmid_hs got valid/ready %b want 01", {out_valid, in_ready}); end
    n_cmp++; if ({sum, err, corrected} !== 11'h000) begin n_bad++; $display("FAIL rstmid_result got %h want 000", {sum, err, corrected}); end
    n_cmp++; if ({op_cnt, err_cnt} !== 8'h00) begin n_bad++; $display("FAIL rstmid_counts got %h want 00", {op_cnt, err_cnt}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_out c%0d got %b want 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_no_error();
    test_correction();
    test_overflow();
    test_backpressure();
    test_saturation();
    test_sweep();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
